// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and stream framing.
package boot_pkg;

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } boot_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles LE words into imem, verifies an XOR check byte,
// then releases the core's reset after a fixed hold.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  In_Valid,
  input  logic [7:0]            In_Data,
  output logic                  In_Ready,
  input  logic                  Reboot,
  output logic                  Imem_We,
  output logic [ADDR_WIDTH-1:0] Imem_Addr,
  output logic [31:0]           Imem_Wdata,
  output logic                  Proc_Reset,
  output logic                  Boot_Done,
  output logic                  Boot_Error
);

  // Word counter is one bit wider than the address so a full-capacity image is expressible.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  boot_state_e           state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic                  prst_q, prst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        take;
  logic [15:0] len_full;

  assign take     = In_Valid && rdy_q;
  assign len_full = {In_Data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    len_lo_d   = len_lo_q;
    xor_d      = xor_q;
    shift_d    = shift_q;
    hold_cnt_d = hold_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_LEN0: begin
        if (take) begin
          len_lo_d = In_Data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (take) begin
          len_d = len_full[CW-1:0];
          if ({16'h0, len_full} > 32'(CAP)) state_d = S_ERR;
          else if (len_full == 16'h0)      state_d = S_CHECK;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (take) begin
          shift_d    = {In_Data, shift_q[23:8]};
          xor_d      = xor_q ^ In_Data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            wdata_d    = {In_Data, shift_q};
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_d == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (take) begin
          hold_cnt_d = 8'd0;
          state_d    = (In_Data == xor_q) ? S_HOLD : S_ERR;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) state_d = S_RUN;
        else hold_cnt_d = hold_cnt_q + 8'd1;
      end
      S_RUN, S_ERR: begin
        if (Reboot) begin
          state_d    = S_LEN0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          xor_d      = '0;
          shift_d    = '0;
        end
      end
      default: state_d = S_LEN0;
    endcase

    // Outputs are registered copies of next-state decode, so they line up with state_q.
    rdy_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
             (state_d == S_DATA) || (state_d == S_CHECK);
    prst_d = (state_d != S_RUN);
    done_d = (state_d == S_RUN);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_LEN0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      len_lo_q   <= '0;
      xor_q      <= '0;
      shift_q    <= '0;
      hold_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdy_q      <= 1'b1;
      prst_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      len_lo_q   <= len_lo_d;
      xor_q      <= xor_d;
      shift_q    <= shift_d;
      hold_cnt_q <= hold_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      prst_q     <= prst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign In_Ready   = rdy_q;
  assign Imem_We    = we_q;
  assign Imem_Addr  = addr_q;
  assign Imem_Wdata = wdata_q;
  assign Proc_Reset = prst_q;
  assign Boot_Done  = done_q;
  assign Boot_Error = err_q;

endmodule
